// File: rtl/hyper_burst_lb_pkg.sv
// Shared definitions for the LocalBus-to-HyperRAM burst bridge: FSM encoding,
// register bit positions and reset defaults.
package hyper_burst_lb_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_GUARD, S_WR_WAIT,
    S_RD_REQ, S_RD_GUARD, S_RD_COLLECT, S_DONE
  } state_t;

  localparam int CTRL_RD    = 0;
  localparam int CTRL_MOR   = 1;
  localparam int CTRL_BE_LO = 4;
  localparam int CTRL_FLUSH = 8;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 28;
  localparam int ST_UNF  = 29;
  localparam int ST_CERR = 30;

  localparam logic [7:0] LAT1X_RST  = 8'h12;
  localparam logic [7:0] LAT2X_RST  = 8'h16;
  localparam logic [5:0] RD_NUM_RST = 6'd1;

  // Zero means a single dword; anything longer than the FIFO is cut to fit.
  function automatic logic [5:0] clamp_len(input logic [5:0] n, input int depth);
    if (n == 6'd0) return 6'd1;
    if (int'(n) > depth) return 6'(depth);
    return n;
  endfunction

endpackage

// File: rtl/hyper_lb_fifo.sv
// Synchronous show-ahead FIFO; dout is the head entry whenever not empty.
// Pushes while full and pops while empty are ignored; flush wins over both.
module hyper_lb_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop_ok)  rp_d = rp_q + 1'b1;
      if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
      if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/hyper_burst_lb.sv
// LocalBus register front end plus burst sequencer driving the hyper_xface
// request port; write data comes from one FIFO, read bursts land in another.
module hyper_burst_lb #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter logic [31:0] ADDR_INC   = 32'd2
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        lb_cs_reg0,
  input  logic        lb_cs_reg1,
  input  logic        lb_cs_reg2,
  input  logic        lb_cs_reg3,
  input  logic        lb_cs_reg4,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_wr_d,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  output logic        hx_rd_req,
  output logic        hx_wr_req,
  output logic        hx_mem_or_reg,
  output logic [3:0]  hx_wr_byte_en,
  output logic [31:0] hx_addr,
  output logic [5:0]  hx_rd_num_dwords,
  output logic [31:0] hx_wr_d,
  output logic [7:0]  hx_latency_1x,
  output logic [7:0]  hx_latency_2x,
  input  logic [31:0] hx_rd_d,
  input  logic        hx_rd_rdy,
  input  logic        hx_busy,
  output logic        irq_done,
  output logic [7:0]  sump_dbg
);
  import hyper_burst_lb_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d, rdata_q, rdata_d, status_w;
  logic [5:0]  rd_num_q, rd_num_d, rd_n_q, rd_n_d, rcv_q, rcv_d;
  logic [7:0]  lat1_q, lat1_d, lat2_q, lat2_d;
  logic [3:0]  be_q, be_d;
  logic        mor_q, mor_d, done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
  logic        cerr_q, cerr_d, rrdy_q, rrdy_d;

  logic [FIFO_AW:0] wr_cnt, rd_cnt;
  logic [31:0]      wr_dout, rd_dout;
  logic wr_full, wr_empty, wr_pop, wr_flush, rd_full, rd_empty, rd_push, rd_pop, rd_flush;
  logic cs_any, cfg_wr, data_wr, addr_wr, ctrl_wr, stat_wr, data_rd;

  assign cs_any  = lb_cs_reg0 | lb_cs_reg1 | lb_cs_reg2 | lb_cs_reg3 | lb_cs_reg4;
  assign cfg_wr  = lb_cs_reg0 & lb_wr;
  assign data_wr = lb_cs_reg1 & lb_wr;
  assign addr_wr = lb_cs_reg2 & lb_wr;
  assign ctrl_wr = lb_cs_reg3 & lb_wr;
  assign stat_wr = lb_cs_reg4 & lb_wr;
  assign data_rd = lb_cs_reg1 & lb_rd;

  hyper_lb_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_wr_fifo (
    .clk(clk_lb), .rst(reset), .flush(wr_flush), .push(data_wr), .pop(wr_pop),
    .din(lb_wr_d), .dout(wr_dout), .count(wr_cnt), .full(wr_full), .empty(wr_empty)
  );

  hyper_lb_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rd_fifo (
    .clk(clk_lb), .rst(reset), .flush(rd_flush), .push(rd_push), .pop(rd_pop),
    .din(hx_rd_d), .dout(rd_dout), .count(rd_cnt), .full(rd_full), .empty(rd_empty)
  );

  assign lb_rd_d          = rdata_q;
  assign lb_rd_rdy        = rrdy_q;
  assign hx_addr          = ptr_q;
  assign hx_wr_d          = wr_dout;
  assign hx_mem_or_reg    = mor_q;
  assign hx_wr_byte_en    = be_q;
  assign hx_rd_num_dwords = rd_n_q;
  assign hx_latency_1x    = lat1_q;
  assign hx_latency_2x    = lat2_q;
  assign irq_done         = done_q;
  assign sump_dbg         = {state_q, wr_empty, rd_empty, ovf_q, unf_q, state_q != S_IDLE};

  always_comb begin
    status_w           = '0;
    status_w[ST_BUSY]  = (state_q != S_IDLE);
    status_w[ST_DONE]  = done_q;
    status_w[12:8]     = 5'(wr_cnt);
    status_w[20:16]    = 5'(rd_cnt);
    status_w[ST_OVF]   = ovf_q;
    status_w[ST_UNF]   = unf_q;
    status_w[ST_CERR]  = cerr_q;
  end

  always_comb begin
    state_d = state_q;  ptr_d = ptr_q;    rd_num_d = rd_num_q;
    lat1_d = lat1_q;    lat2_d = lat2_q;  be_d = be_q;  mor_d = mor_q;
    rd_n_d = rd_n_q;    rcv_d = rcv_q;    done_d = done_q;
    ovf_d = ovf_q;      unf_d = unf_q;    cerr_d = cerr_q;
    rdata_d = '0;       rrdy_d = lb_rd & cs_any;
    wr_pop = 1'b0;  wr_flush = 1'b0;  rd_push = 1'b0;  rd_pop = 1'b0;  rd_flush = 1'b0;
    hx_wr_req = 1'b0;  hx_rd_req = 1'b0;

    // Clears come first so a same-cycle set event is never lost.
    if (stat_wr) begin
      if (lb_wr_d[ST_DONE]) done_d = 1'b0;
      if (lb_wr_d[ST_OVF])  ovf_d  = 1'b0;
      if (lb_wr_d[ST_UNF])  unf_d  = 1'b0;
      if (lb_wr_d[ST_CERR]) cerr_d = 1'b0;
    end
    if (cfg_wr) begin
      rd_num_d = lb_wr_d[5:0];
      lat1_d   = lb_wr_d[23:16];
      lat2_d   = lb_wr_d[31:24];
    end
    if (addr_wr) ptr_d = lb_wr_d;
    if (data_wr && wr_full) ovf_d = 1'b1;
    if (data_rd) begin
      rd_pop = 1'b1;
      if (rd_empty) unf_d = 1'b1;
    end

    if (hx_rd_rdy && (state_q == S_RD_GUARD || state_q == S_RD_COLLECT)) begin
      if (rcv_q != rd_n_q && !rd_full) begin
        rd_push = 1'b1;
        rcv_d   = rcv_q + 6'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (ctrl_wr) begin
      if (state_q != S_IDLE) begin
        cerr_d = 1'b1;
      end else if (lb_wr_d[CTRL_FLUSH]) begin
        wr_flush = 1'b1;
        rd_flush = 1'b1;
      end else begin
        mor_d = lb_wr_d[CTRL_MOR];
        be_d  = lb_wr_d[CTRL_BE_LO +: 4];
        if (lb_wr_d[CTRL_RD]) begin
          rd_flush = 1'b1;
          rd_n_d   = clamp_len(rd_num_q, FIFO_DEPTH);
          rcv_d    = '0;
          state_d  = S_RD_REQ;
        end else begin
          state_d  = wr_empty ? S_DONE : S_WR_REQ;
        end
      end
    end

    case (state_q)
      S_WR_REQ:   begin hx_wr_req = 1'b1; state_d = S_WR_GUARD; end
      S_WR_GUARD: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (!hx_busy) begin
          wr_pop  = 1'b1;
          ptr_d   = ptr_q + ADDR_INC;
          // A same-cycle LB push keeps the burst going.
          state_d = (wr_cnt == {{FIFO_AW{1'b0}}, 1'b1} && !data_wr) ? S_DONE : S_WR_REQ;
        end
      end
      S_RD_REQ:   begin hx_rd_req = 1'b1; state_d = S_RD_GUARD; end
      S_RD_GUARD: state_d = S_RD_COLLECT;
      S_RD_COLLECT: begin
        if (rcv_q == rd_n_q && !hx_busy) begin
          ptr_d   = ptr_q + 32'(rd_n_q) * ADDR_INC;
          state_d = S_DONE;
        end
      end
      S_DONE:     begin done_d = 1'b1; state_d = S_IDLE; end
      default:    ;
    endcase

    if (lb_rd) begin
      if (lb_cs_reg0)      rdata_d = {lat2_q, lat1_q, 10'b0, rd_num_q};
      else if (lb_cs_reg1) rdata_d = rd_empty ? 32'h0 : rd_dout;
      else if (lb_cs_reg2) rdata_d = ptr_q;
      else if (lb_cs_reg4) rdata_d = status_w;
    end
  end

  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  ptr_q <= '0;  rd_num_q <= RD_NUM_RST;
      lat1_q <= LAT1X_RST;  lat2_q <= LAT2X_RST;  be_q <= '0;  mor_q <= 1'b0;
      rd_n_q <= RD_NUM_RST;  rcv_q <= '0;  done_q <= 1'b0;
      ovf_q <= 1'b0;  unf_q <= 1'b0;  cerr_q <= 1'b0;
      rdata_q <= '0;  rrdy_q <= 1'b0;
    end else begin
      state_q <= state_d;  ptr_q <= ptr_d;  rd_num_q <= rd_num_d;
      lat1_q <= lat1_d;  lat2_q <= lat2_d;  be_q <= be_d;  mor_q <= mor_d;
      rd_n_q <= rd_n_d;  rcv_q <= rcv_d;  done_q <= done_d;
      ovf_q <= ovf_d;  unf_q <= unf_d;  cerr_q <= cerr_d;
      rdata_q <= rdata_d;  rrdy_q <= rrdy_d;
    end
  end

endmodule

// File: tb/tb_hyper_burst_lb.sv
// Directed bench for hyper_burst_lb: register table plus burst sequences
// against a small hyper_xface responder.
module tb_hyper_burst_lb;
  logic        clk_lb = 1'b0, reset = 1'b1;
  logic [4:0]  cs = '0;
  logic        lb_wr = 1'b0, lb_rd = 1'b0;
  logic [31:0] lb_wr_d = '0, lb_rd_d, hx_addr, hx_wr_d, hx_rd_d;
  logic        lb_rd_rdy, hx_rd_req, hx_wr_req, hx_mem_or_reg, hx_rd_rdy, hx_busy, irq_done;
  logic [3:0]  hx_wr_byte_en;
  logic [5:0]  hx_rd_num_dwords;
  logic [7:0]  hx_latency_1x, hx_latency_2x, sump_dbg;

  int n_chk = 0, n_fail = 0;
  int rd_req_cnt = 0, rd_req_n = 0, wr_req_cycles = 0;
  logic [31:0] rd_base = 32'hD000_0000;
  logic [31:0] wa_q[$], wd_q[$];
  logic [3:0]  be_q[$];
  logic        mor_q[$];

  typedef struct { bit wr; int r; logic [31:0] d; string nm; } vec_t;
  vec_t tbl[$];

  always #5 clk_lb = ~clk_lb;

  hyper_burst_lb dut (
    .clk_lb(clk_lb), .reset(reset),
    .lb_cs_reg0(cs[0]), .lb_cs_reg1(cs[1]), .lb_cs_reg2(cs[2]), .lb_cs_reg3(cs[3]), .lb_cs_reg4(cs[4]),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_wr_d(lb_wr_d), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
    .hx_rd_req(hx_rd_req), .hx_wr_req(hx_wr_req), .hx_mem_or_reg(hx_mem_or_reg),
    .hx_wr_byte_en(hx_wr_byte_en), .hx_addr(hx_addr), .hx_rd_num_dwords(hx_rd_num_dwords),
    .hx_wr_d(hx_wr_d), .hx_latency_1x(hx_latency_1x), .hx_latency_2x(hx_latency_2x),
    .hx_rd_d(hx_rd_d), .hx_rd_rdy(hx_rd_rdy), .hx_busy(hx_busy),
    .irq_done(irq_done), .sump_dbg(sump_dbg)
  );

  always @(negedge clk_lb) if (hx_wr_req) wr_req_cycles++;

  // xface responder: busy for 3 cycles per write, read bursts stream rd_base+i.
  initial begin
    hx_busy = 1'b0; hx_rd_rdy = 1'b0; hx_rd_d = '0;
    forever begin
      @(negedge clk_lb);
      hx_rd_rdy = 1'b0;
      if (hx_wr_req) begin
        wa_q.push_back(hx_addr); wd_q.push_back(hx_wr_d);
        be_q.push_back(hx_wr_byte_en); mor_q.push_back(hx_mem_or_reg);
        hx_busy = 1'b1;
        repeat (3) @(negedge clk_lb);
        hx_busy = 1'b0;
      end else if (hx_rd_req) begin
        rd_req_n = int'(hx_rd_num_dwords);
        rd_req_cnt++;
        hx_busy = 1'b1;
        for (int i = 0; i < rd_req_n; i++) begin
          @(negedge clk_lb);
          hx_rd_rdy = 1'b1; hx_rd_d = rd_base + 32'(i);
        end
        @(negedge clk_lb); hx_rd_rdy = 1'b0;
        @(negedge clk_lb); hx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic lb_write(input int r, input logic [31:0] d);
    @(negedge clk_lb); cs = 5'(1 << r); lb_wr = 1'b1; lb_wr_d = d;
    @(negedge clk_lb); cs = '0; lb_wr = 1'b0;
  endtask

  task automatic lb_read(input int r, output logic [31:0] d);
    @(negedge clk_lb); cs = 5'(1 << r); lb_rd = 1'b1;
    @(negedge clk_lb); cs = '0; lb_rd = 1'b0;
    chk("rd_rdy", {31'b0, lb_rd_rdy}, 32'd1);
    d = lb_rd_d;
  endtask

  task automatic rd_chk(input int r, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    lb_read(r, d);
    chk(nm, d, exp);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!irq_done && k < 500) begin @(negedge clk_lb); k++; end
    chk(nm, {31'b0, irq_done}, 32'd1);
  endtask

  task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d);
    chk("wr_addr", (i < wa_q.size()) ? wa_q[i] : 32'hFFFF_FFFF, a);
    chk("wr_data", (i < wd_q.size()) ? wd_q[i] : 32'hFFFF_FFFF, d);
  endtask

  function automatic vec_t mkv(bit wr, int r, logic [31:0] d, string nm);
    vec_t v;
    v.wr = wr; v.r = r; v.d = d; v.nm = nm;
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    int k, snap;

    repeat (3) @(negedge clk_lb);
    chk("rst_sump", {24'b0, sump_dbg}, 32'h18);
    reset = 1'b0;
    @(negedge clk_lb);
    chk("rst_addr", hx_addr, 32'h0);
    chk("rst_rdnum", {26'b0, hx_rd_num_dwords}, 32'd1);
    chk("rst_lat", {16'b0, hx_latency_2x, hx_latency_1x}, 32'h1612);
    chk("rst_req", {30'b0, hx_wr_req, hx_rd_req}, 32'h0);

    tbl.push_back(mkv(0, 0, 32'h1612_0001, "cfg_rst"));
    tbl.push_back(mkv(0, 4, 32'h0000_0000, "status_rst"));
    tbl.push_back(mkv(0, 2, 32'h0000_0000, "addr_rst"));
    tbl.push_back(mkv(1, 0, 32'hAABB_FFC5, ""));
    tbl.push_back(mkv(0, 0, 32'hAABB_0005, "cfg_mask"));
    tbl.push_back(mkv(1, 0, 32'h1612_0004, ""));
    tbl.push_back(mkv(1, 2, 32'h0000_0100, ""));
    tbl.push_back(mkv(0, 2, 32'h0000_0100, "addr_rw"));
    tbl.push_back(mkv(1, 1, 32'hA000_0000, ""));
    tbl.push_back(mkv(1, 1, 32'hA000_0001, ""));
    tbl.push_back(mkv(1, 1, 32'hA000_0002, ""));
    tbl.push_back(mkv(0, 4, 32'h0000_0300, "status_wcnt3"));
    tbl.push_back(mkv(0, 3, 32'h0000_0000, "ctrl_reads0"));
    tbl.push_back(mkv(0, 1, 32'h0000_0000, "data_empty"));
    tbl.push_back(mkv(0, 4, 32'h2000_0300, "status_unf"));
    tbl.push_back(mkv(1, 4, 32'h2000_0000, ""));
    tbl.push_back(mkv(0, 4, 32'h0000_0300, "status_unf_clr"));

    foreach (tbl[i]) begin
      if (tbl[i].wr) lb_write(tbl[i].r, tbl[i].d);
      else begin
        rd_chk(tbl[i].r, tbl[i].d, tbl[i].nm);
        @(negedge clk_lb);
        chk("rd_idle", lb_rd_d | {31'b0, lb_rd_rdy}, 32'h0);
      end
    end

    // Three-dword write burst from 0x100.
    lb_write(3, 32'h0000_00F0);
    wait_done("wr_done");
    chk("wr_count", 32'(wa_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk_wr(i, 32'h100 + 32'(2 * i), 32'hA000_0000 + 32'(i));
    chk("wr_be", (be_q.size() > 0) ? {28'b0, be_q[0]} : 32'hFFFF_FFFF, 32'hF);
    chk("wr_mor", (mor_q.size() > 0) ? {31'b0, mor_q[0]} : 32'hFFFF_FFFF, 32'h0);
    rd_chk(4, 32'h0000_0002, "wr_status");
    rd_chk(2, 32'h0000_0106, "wr_ptr");
    lb_write(4, 32'h0000_0002);
    rd_chk(4, 32'h0, "done_clr");

    // Four-dword read burst.
    lb_write(3, 32'h0000_0001);
    wait_done("rd_done");
    chk("rd_req_n", 32'(rd_req_n), 32'd4);
    chk("rd_req_cnt", 32'(rd_req_cnt), 32'd1);
    rd_chk(4, 32'h0004_0002, "rd_status");
    rd_chk(2, 32'h0000_010E, "rd_ptr");
    for (int i = 0; i < 4; i++) rd_chk(1, rd_base + 32'(i), "rd_data");
    rd_chk(1, 32'h0, "rd_data_unf");
    rd_chk(4, 32'h2000_0002, "rd_status_unf");
    lb_write(4, 32'h2000_0002);

    // Overflow of the write FIFO, then flush.
    for (int i = 0; i < 17; i++) lb_write(1, 32'h5000_0000 + 32'(i));
    rd_chk(4, 32'h1000_1000, "ovf_status");
    lb_write(4, 32'h1000_0000);
    rd_chk(4, 32'h0000_1000, "ovf_clr");
    lb_write(3, 32'h0000_0100);
    rd_chk(4, 32'h0, "flush_status");

    // Command during a write burst is rejected; a mid-burst push extends it.
    wa_q.delete(); wd_q.delete();
    snap = rd_req_cnt;
    lb_write(1, 32'hB000_0000);
    lb_write(1, 32'hB000_0001);
    lb_write(2, 32'h0000_0200);
    lb_write(3, 32'h0000_00F0);
    lb_write(3, 32'h0000_0001);
    lb_write(1, 32'hB000_0002);
    wait_done("cerr_done");
    chk("cerr_wr_count", 32'(wa_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk_wr(i, 32'h200 + 32'(2 * i), 32'hB000_0000 + 32'(i));
    chk("cerr_no_rd", 32'(rd_req_cnt), 32'(snap));
    rd_chk(4, 32'h4000_0002, "cerr_status");
    rd_chk(2, 32'h0000_0206, "cerr_ptr");
    lb_write(4, 32'h4000_0002);

    // rd_num of zero is a single-dword burst.
    lb_write(0, 32'h1612_0000);
    lb_write(3, 32'h0000_0001);
    wait_done("rd0_done");
    chk("rd0_n", 32'(rd_req_n), 32'd1);
    rd_chk(4, 32'h0001_0002, "rd0_status");
    rd_chk(1, rd_base, "rd0_data");
    rd_chk(2, 32'h0000_0208, "rd0_ptr");
    lb_write(4, 32'h0000_0002);

    // Reset during WR_WAIT of a four-dword burst.
    wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 4; i++) lb_write(1, 32'hC000_0000 + 32'(i));
    lb_write(2, 32'h0000_0300);
    lb_write(3, 32'h0000_00F0);
    k = 0;
    while (wa_q.size() < 2 && k < 200) begin @(negedge clk_lb); k++; end
    chk("rst_mid_reach", 32'(wa_q.size()), 32'd2);
    repeat (2) @(negedge clk_lb);
    chk("rst_mid_state", {29'b0, sump_dbg[7:5]}, 32'(3));
    reset = 1'b1;
    @(negedge clk_lb);
    snap = wr_req_cycles;
    @(negedge clk_lb);
    reset = 1'b0;
    repeat (40) @(negedge clk_lb);
    chk("rst_no_req", 32'(wr_req_cycles), 32'(snap));
    chk("rst_sump_after", {24'b0, sump_dbg}, 32'h18);
    rd_chk(4, 32'h0, "rst_status");
    rd_chk(0, 32'h1612_0001, "rst_cfg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
